// File: rtl/sqrt_feeder_pkg.sv
// Shared types and defaults for the sqrt request feeder.
package sqrt_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam int N_DEF       = 16;
  localparam int Q_DEF       = 0;
  localparam int DEPTH_DEF   = 4;
  localparam int TAG_W_DEF   = 4;
  localparam int TIMEOUT_DEF = 64;

  function automatic int calc_iter(input int n, input int q);
    return (n + q) >> 1;
  endfunction

endpackage

// File: rtl/sqrt_req_fifo.sv
// Request FIFO: DEPTH entries of W bits, show-ahead read, async active-low reset.
module sqrt_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 20,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/sqrt_feeder.sv
// Streams tagged radicands into the iterative sqrt core and returns results on a valid/ready port.
// Optional WAIT-state watchdog enabled by defining SQRT_FEEDER_TIMEOUT_EN.
module sqrt_feeder
  import sqrt_feeder_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int Q       = Q_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       req_valid_in,
  output logic                       req_ready_out,
  input  logic [N-1:0]               req_rad_in,
  input  logic [TAG_W-1:0]           req_tag_in,
  output logic                       sqrt_start_out,
  output logic [N-1:0]               sqrt_rad_out,
  input  logic                       sqrt_busy_in,
  input  logic                       sqrt_valid_in,
  input  logic [N-1:0]               sqrt_root_in,
  input  logic [N-1:0]               sqrt_rem_in,
  output logic                       res_valid_out,
  input  logic                       res_ready_in,
  output logic [N-1:0]               res_root_out,
  output logic [N-1:0]               res_rem_out,
  output logic [TAG_W-1:0]           res_tag_out,
  output logic                       res_exact_out,
  output logic                       res_timeout_out,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level_out
);

  localparam int ITER = calc_iter(N, Q);
  localparam int FW   = N + TAG_W;

  if (TIMEOUT <= ITER + 2) begin : g_bad_timeout
    $error("sqrt_feeder: TIMEOUT must exceed ITER+2");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sqrt_feeder: DEPTH must be a power of two >= 2");
  end

  state_e            state_q, state_d;
  logic              fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [FW-1:0]     fifo_head;
  logic [N-1:0]      rad_q, root_q, rem_q;
  logic [TAG_W-1:0]  tag_q, rtag_q;
  logic              res_valid_q, res_valid_d, exact_q;
  logic              core_done, slot_free, timed_out, capture;

  assign fifo_push = req_valid_in & req_ready_out;
  assign fifo_pop  = (state_q == ST_IDLE) & ~fifo_empty;

  sqrt_req_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
    .clk_i   (clk_in),
    .rst_ni  (rst_n_in),
    .push_i  (fifo_push),
    .data_i  ({req_rad_in, req_tag_in}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_out)
  );

  assign req_ready_out = ~fifo_full;

  // Core flags are only trusted in WAIT: the core has no reset.
  assign core_done = (state_q == ST_WAIT) & sqrt_valid_in & ~sqrt_busy_in;
  assign slot_free = ~res_valid_q | res_ready_in;
  assign capture   = (core_done | timed_out) & slot_free;

`ifdef SQRT_FEEDER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] to_cnt_q;
  logic          res_to_q;

  assign timed_out = (state_q == ST_WAIT) & ~core_done & (to_cnt_q == CW'(TIMEOUT));

  // Counter parks at TIMEOUT so slot-full stalls do not advance it further.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      to_cnt_q <= '0;
      res_to_q <= 1'b0;
    end else begin
      if (state_q == ST_ISSUE) to_cnt_q <= '0;
      else if ((state_q == ST_WAIT) && !core_done && (to_cnt_q != CW'(TIMEOUT)))
        to_cnt_q <= to_cnt_q + CW'(1);
      if (capture) res_to_q <= timed_out;
    end
  end

  assign res_timeout_out = res_to_q;
`else
  assign timed_out       = 1'b0;
  assign res_timeout_out = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (capture) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    res_valid_d = res_valid_q;
    if (capture) res_valid_d = 1'b1;
    else if (res_valid_q && res_ready_in) res_valid_d = 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_IDLE;
      rad_q       <= '0;
      tag_q       <= '0;
      res_valid_q <= 1'b0;
      root_q      <= '0;
      rem_q       <= '0;
      rtag_q      <= '0;
      exact_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_valid_q <= res_valid_d;
      if (fifo_pop) begin
        rad_q <= fifo_head[FW-1:TAG_W];
        tag_q <= fifo_head[TAG_W-1:0];
      end
      if (capture) begin
        root_q  <= timed_out ? '0 : sqrt_root_in;
        rem_q   <= timed_out ? '0 : sqrt_rem_in;
        rtag_q  <= tag_q;
        exact_q <= ~timed_out & (sqrt_rem_in == '0);
      end
    end
  end

  assign sqrt_start_out = (state_q == ST_ISSUE);
  assign sqrt_rad_out   = rad_q;
  assign res_valid_out  = res_valid_q;
  assign res_root_out   = root_q;
  assign res_rem_out    = rem_q;
  assign res_tag_out    = rtag_q;
  assign res_exact_out  = exact_q;

endmodule
